// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared encodings for the ID/EX ALU control block:
//   - main-control alu_op codes for I-type instructions (R-type is all-ones)
//   - R-type funct codes
//   - ALU operation select codes, including the illegal/MULT/DIV codes
//   - state enum for the multiply/divide sequencer
// The codes are stored at their minimum widths. Users zero-extend them to
// their parameterised port widths.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

    // I-type alu_op codes (funct is ignored for these)
    localparam logic [2:0] ALUOP_MEM    = 3'b000;  // LW / SW
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;  // BEQ / BNE
    localparam logic [2:0] ALUOP_SLTI   = 3'b010;
    localparam logic [2:0] ALUOP_ANDI   = 3'b011;
    localparam logic [2:0] ALUOP_ADDI   = 3'b100;
    localparam logic [2:0] ALUOP_ORI    = 3'b101;
    localparam logic [2:0] ALUOP_LUI    = 3'b110;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    // ALU operation select codes
    localparam logic [3:0] SEL_AND     = 4'b0000;
    localparam logic [3:0] SEL_NOR     = 4'b0001;
    localparam logic [3:0] SEL_OR      = 4'b0010;
    localparam logic [3:0] SEL_ADD     = 4'b0011;
    localparam logic [3:0] SEL_SUB     = 4'b0100;
    localparam logic [3:0] SEL_LUI     = 4'b0101;
    localparam logic [3:0] SEL_SLT     = 4'b0110;
    localparam logic [3:0] SEL_SLL     = 4'b0111;
    localparam logic [3:0] SEL_SRL     = 4'b1000;
    localparam logic [3:0] SEL_ILLEGAL = 4'b1001;
    localparam logic [3:0] SEL_MULT    = 4'b1010;
    localparam logic [3:0] SEL_DIV     = 4'b1011;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_BUSY = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_mdu_seq.sv
// ---------------------------------------------------------------------------
// alu_mdu_seq
// Sequencer for multi-cycle MULT/DIV operations.
// On launch it enters BUSY for exactly MUL_LAT or DIV_LAT cycles. It then
// spends one cycle in DONE, where done pulses, and returns to IDLE.
// A launch is accepted in DONE as well as in IDLE, so back-to-back
// operations are possible.
// A flush during BUSY returns the FSM to IDLE without a done pulse.
// Ports:
//   clk, reset   clock / asynchronous active-high reset
//   launch_i     accepted MULT/DIV instruction this cycle
//   kind_i       0 = MULT, 1 = DIV (valid with launch_i)
//   flush_i      abort an in-flight operation
//   mdu_start_o  one-cycle pulse after the launch edge
//   mdu_kind_o   kind of the last launched operation
//   mdu_busy_o   high while in BUSY
//   mdu_done_o   one-cycle pulse when the result is ready
// ---------------------------------------------------------------------------
module alu_mdu_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic launch_i,
    input  logic kind_i,
    input  logic flush_i,
    output logic mdu_start_o,
    output logic mdu_kind_o,
    output logic mdu_busy_o,
    output logic mdu_done_o
);

    localparam int CNT_W = $clog2(max_int(MUL_LAT, DIV_LAT)) + 1;

    mdu_state_e       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             start_reg, start_next;
    logic             kind_reg, kind_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= MDU_IDLE;
            cnt_reg   <= '0;
            start_reg <= 1'b0;
            kind_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            start_reg <= start_next;
            kind_reg  <= kind_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        start_next = 1'b0;
        kind_next  = kind_reg;
        case (state_reg)
            MDU_BUSY: begin
                // The count is loaded with LAT-1. BUSY therefore covers
                // counter values LAT-1 down to 0, which is LAT cycles.
                if (flush_i) begin
                    state_next = MDU_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = MDU_DONE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                // IDLE and DONE behave the same way.
                if (launch_i) begin
                    state_next = MDU_BUSY;
                    cnt_next   = kind_i ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                    start_next = 1'b1;
                    kind_next  = kind_i;
                end else begin
                    state_next = MDU_IDLE;
                end
            end
        endcase
    end

    assign mdu_start_o = start_reg;
    assign mdu_kind_o  = kind_reg;
    assign mdu_busy_o  = (state_reg == MDU_BUSY);
    assign mdu_done_o  = (state_reg == MDU_DONE);

endmodule

// File: rtl/alu_control_pipe.sv
// ---------------------------------------------------------------------------
// alu_control_pipe
// ALU control for the pipelined MIPS core at the ID/EX boundary.
// It decodes {alu_op, funct} into an ALU operation code and registers the
// result into EX with one cycle of latency. It honours stall and flush.
//
// Build option ALU_CTRL_MDU_EN:
//   defined     MULT/DIV decode to 1010/1011 and are sequenced by
//               alu_mdu_seq. Its busy output also holds the pipeline.
//   undefined   MULT/DIV decode as illegal, the mdu_* outputs are tied
//               to 0 and the pipeline holds only on stall_i.
// Ports:
//   clk, reset        clock / asynchronous active-high reset
//   valid_i           ID-stage instruction valid
//   stall_i           hazard stall, holds the output register
//   flush_i           squashes the ID instruction and aborts an MDU op
//   alu_op_i          main-control ALU op
//   alu_function_i    funct field
//   alu_operation_o   registered ALU operation code
//   valid_o           EX-stage valid
//   illegal_o         registered: a valid instruction had no decode match
//   mdu_start_o/kind_o/busy_o/done_o   multiply/divide sequencing
// ---------------------------------------------------------------------------
module alu_control_pipe
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_OP_W  = 3,
    parameter int FUNCT_W   = 6,
    parameter int ALU_SEL_W = 4,
    parameter int MUL_LAT   = 4,
    parameter int DIV_LAT   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic [ALU_OP_W-1:0]  alu_op_i,
    input  logic [FUNCT_W-1:0]   alu_function_i,
    output logic [ALU_SEL_W-1:0] alu_operation_o,
    output logic                 valid_o,
    output logic                 illegal_o,
    output logic                 mdu_start_o,
    output logic                 mdu_kind_o,
    output logic                 mdu_busy_o,
    output logic                 mdu_done_o
);

    logic [ALU_SEL_W-1:0] dec_op;
    logic                 dec_nomatch;
    logic                 hold;
    logic [ALU_SEL_W-1:0] op_reg;
    logic                 valid_reg;
    logic                 illegal_reg;
`ifdef ALU_CTRL_MDU_EN
    logic                 dec_is_mdu;
    logic                 dec_is_div;
`endif

    // ---------------- decode ----------------
    always_comb begin
        dec_op      = ALU_SEL_W'(SEL_ILLEGAL);
        dec_nomatch = 1'b1;
`ifdef ALU_CTRL_MDU_EN
        dec_is_mdu  = 1'b0;
        dec_is_div  = 1'b0;
`endif
        if (alu_op_i == {ALU_OP_W{1'b1}}) begin
            dec_nomatch = 1'b0;
            case (alu_function_i)
                FUNCT_W'(FUNCT_ADD),
                FUNCT_W'(FUNCT_ADDU): dec_op = ALU_SEL_W'(SEL_ADD);
                FUNCT_W'(FUNCT_SUB),
                FUNCT_W'(FUNCT_SUBU): dec_op = ALU_SEL_W'(SEL_SUB);
                FUNCT_W'(FUNCT_AND):  dec_op = ALU_SEL_W'(SEL_AND);
                FUNCT_W'(FUNCT_OR):   dec_op = ALU_SEL_W'(SEL_OR);
                FUNCT_W'(FUNCT_NOR):  dec_op = ALU_SEL_W'(SEL_NOR);
                FUNCT_W'(FUNCT_SLT):  dec_op = ALU_SEL_W'(SEL_SLT);
                FUNCT_W'(FUNCT_SLL):  dec_op = ALU_SEL_W'(SEL_SLL);
                FUNCT_W'(FUNCT_SRL):  dec_op = ALU_SEL_W'(SEL_SRL);
`ifdef ALU_CTRL_MDU_EN
                FUNCT_W'(FUNCT_MULT): begin
                    dec_op     = ALU_SEL_W'(SEL_MULT);
                    dec_is_mdu = 1'b1;
                end
                FUNCT_W'(FUNCT_DIV): begin
                    dec_op     = ALU_SEL_W'(SEL_DIV);
                    dec_is_mdu = 1'b1;
                    dec_is_div = 1'b1;
                end
`endif
                default: dec_nomatch = 1'b1;
            endcase
        end else begin
            dec_nomatch = 1'b0;
            case (alu_op_i)
                ALU_OP_W'(ALUOP_MEM),
                ALU_OP_W'(ALUOP_ADDI):   dec_op = ALU_SEL_W'(SEL_ADD);
                ALU_OP_W'(ALUOP_BRANCH): dec_op = ALU_SEL_W'(SEL_SUB);
                ALU_OP_W'(ALUOP_SLTI):   dec_op = ALU_SEL_W'(SEL_SLT);
                ALU_OP_W'(ALUOP_ANDI):   dec_op = ALU_SEL_W'(SEL_AND);
                ALU_OP_W'(ALUOP_ORI):    dec_op = ALU_SEL_W'(SEL_OR);
                ALU_OP_W'(ALUOP_LUI):    dec_op = ALU_SEL_W'(SEL_LUI);
                default:                 dec_nomatch = 1'b1;
            endcase
        end
    end

    // ---------------- multiply/divide sequencing ----------------
`ifdef ALU_CTRL_MDU_EN
    logic accept;
    // An instruction is accepted only when it actually enters EX.
    // Launching on a held or flushed instruction would start a phantom op.
    assign accept = valid_i & ~hold & ~flush_i;
    assign hold   = stall_i | mdu_busy_o;

    alu_mdu_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu_seq (
        .clk         (clk),
        .reset       (reset),
        .launch_i    (accept & dec_is_mdu),
        .kind_i      (dec_is_div),
        .flush_i     (flush_i),
        .mdu_start_o (mdu_start_o),
        .mdu_kind_o  (mdu_kind_o),
        .mdu_busy_o  (mdu_busy_o),
        .mdu_done_o  (mdu_done_o)
    );
`else
    assign hold        = stall_i;
    assign mdu_start_o = 1'b0;
    assign mdu_kind_o  = 1'b0;
    assign mdu_busy_o  = 1'b0;
    assign mdu_done_o  = 1'b0;
`endif

    // ---------------- ID/EX register ----------------
    // Flush overrides hold. It clears valid and illegal, and the stale
    // operation code stays in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_reg      <= ALU_SEL_W'(SEL_ILLEGAL);
            valid_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (flush_i) begin
            valid_reg   <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (!hold) begin
            op_reg      <= dec_op;
            illegal_reg <= valid_i & dec_nomatch;
            valid_reg   <= valid_i;
        end
    end

    assign alu_operation_o = op_reg;
    assign valid_o         = valid_reg;
    assign illegal_o       = illegal_reg;

endmodule

// File: tb/tb_alu_control_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_control_pipe
// Directed scenarios followed by random stimulus. Each cycle, every output
// is compared against a reference model kept in this bench. The model
// tracks the number of remaining busy cycles and uses decode tables.
// It handles both builds, with and without ALU_CTRL_MDU_EN.
// ---------------------------------------------------------------------------
module tb_alu_control_pipe;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
`ifdef ALU_CTRL_MDU_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_i, stall_i, flush_i;
    logic [2:0] alu_op_i;
    logic [5:0] alu_function_i;
    logic [3:0] alu_operation_o;
    logic       valid_o, illegal_o;
    logic       mdu_start_o, mdu_kind_o, mdu_busy_o, mdu_done_o;

    always #5 clk = ~clk;

    alu_control_pipe #(
        .ALU_OP_W  (3),
        .FUNCT_W   (6),
        .ALU_SEL_W (4),
        .MUL_LAT   (MUL_LAT),
        .DIV_LAT   (DIV_LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .alu_op_i        (alu_op_i),
        .alu_function_i  (alu_function_i),
        .alu_operation_o (alu_operation_o),
        .valid_o         (valid_o),
        .illegal_o       (illegal_o),
        .mdu_start_o     (mdu_start_o),
        .mdu_kind_o      (mdu_kind_o),
        .mdu_busy_o      (mdu_busy_o),
        .mdu_done_o      (mdu_done_o)
    );

    // ---------------- decode tables ----------------
    logic [5:0] r_funct [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                 6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000010};
    logic [3:0] r_sel   [10] = '{4'd3, 4'd3, 4'd4, 4'd4, 4'd0, 4'd2, 4'd1, 4'd6, 4'd7, 4'd8};
    logic [3:0] i_sel   [7]  = '{4'd3, 4'd4, 4'd6, 4'd0, 4'd3, 4'd2, 4'd5};
    logic [5:0] pick_funct [12] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                    6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b000010,
                                    6'b011000, 6'b011010};

    // ---------------- reference model state ----------------
    logic [3:0] m_op;
    bit         m_valid, m_ill, m_start, m_kind, m_done;
    int         busy_left;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic void ref_decode(input logic [2:0] aop, input logic [5:0] fn,
                                       output logic [3:0] sel, output bit nomatch,
                                       output bit mdu, output bit div);
        sel = 4'b1001; nomatch = 1'b1; mdu = 1'b0; div = 1'b0;
        if (aop == 3'b111) begin
            for (int i = 0; i < 10; i++)
                if (fn == r_funct[i]) begin sel = r_sel[i]; nomatch = 1'b0; end
            if (MDU_EN && fn == 6'b011000) begin sel = 4'b1010; nomatch = 1'b0; mdu = 1'b1; end
            if (MDU_EN && fn == 6'b011010) begin sel = 4'b1011; nomatch = 1'b0; mdu = 1'b1; div = 1'b1; end
        end else begin
            sel = i_sel[aop];
            nomatch = 1'b0;
        end
    endfunction

    task automatic model_reset();
        m_op = 4'b1001; m_valid = 0; m_ill = 0;
        m_start = 0; m_kind = 0; m_done = 0; busy_left = 0;
    endtask

    task automatic model_step();
        logic [3:0] sel;
        bit nm, mdu, div, hold, acc;
        ref_decode(alu_op_i, alu_function_i, sel, nm, mdu, div);
        hold = stall_i || (busy_left > 0);
        acc  = valid_i && !hold && !flush_i;
        if (flush_i) begin
            m_valid = 0; m_ill = 0;
        end else if (!hold) begin
            m_op = sel; m_ill = valid_i && nm; m_valid = valid_i;
        end
        m_start = 0; m_done = 0;
        if (busy_left > 0) begin
            if (flush_i) busy_left = 0;
            else begin
                busy_left--;
                if (busy_left == 0) m_done = 1;
            end
        end else if (acc && mdu) begin
            busy_left = div ? DIV_LAT : MUL_LAT;
            m_start   = 1;
            m_kind    = div;
        end
        if (acc)
            $display("txn cyc=%0d alu_op=%b funct=%b -> op=%b illegal=%0d", cyc, alu_op_i, alu_function_i, sel, nm);
    endtask

    task automatic check_all();
        check_val("alu_operation", int'(alu_operation_o), int'(m_op));
        check_val("valid_o",   int'(valid_o),     int'(m_valid));
        check_val("illegal_o", int'(illegal_o),   int'(m_ill));
        check_val("mdu_start", int'(mdu_start_o), int'(m_start));
        check_val("mdu_kind",  int'(mdu_kind_o),  int'(m_kind));
        check_val("mdu_busy",  int'(mdu_busy_o),  int'(busy_left > 0));
        check_val("mdu_done",  int'(mdu_done_o),  int'(m_done));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!reset) model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input bit v, input bit s, input bit f, input logic [2:0] aop, input logic [5:0] fn);
        valid_i = v; stall_i = s; flush_i = f; alu_op_i = aop; alu_function_i = fn;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 3'b000, 6'b000000);
        model_reset();
        #1;
        check_all();
        tick();
        @(negedge clk);
        reset = 1'b0;

        // basic decode
        drive(1, 0, 0, 3'b111, 6'b100010); tick();
        drive(1, 0, 0, 3'b110, 6'b101010); tick();
        drive(1, 0, 0, 3'b111, 6'b111111); tick();
        drive(1, 0, 0, 3'b111, 6'b100000); tick();

        // stall with changing inputs, then flush together with stall
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 3'(i), 6'b100101); tick();
        end
        drive(1, 1, 1, 3'b101, 6'b000000); tick();
        drive(0, 0, 0, 3'b000, 6'b000000); tick();

        // MULT followed by an ADD that must wait for busy to fall
        drive(1, 0, 0, 3'b111, 6'b011000); tick();
        drive(1, 0, 0, 3'b111, 6'b100000);
        for (int i = 0; i < 7; i++) tick();

        // DIV aborted by flush at its tenth busy cycle, then a clean MULT
        drive(1, 0, 0, 3'b111, 6'b011010); tick();
        drive(0, 0, 0, 3'b000, 6'b000000);
        for (int i = 0; i < 9; i++) tick();
        drive(0, 0, 1, 3'b000, 6'b000000); tick();
        drive(1, 0, 0, 3'b111, 6'b011000); tick();
        drive(0, 0, 0, 3'b000, 6'b000000);
        for (int i = 0; i < 7; i++) tick();

        // back-to-back MULTs: the second is accepted in DONE
        drive(1, 0, 0, 3'b111, 6'b011000);
        for (int i = 0; i < 12; i++) tick();

        // reset asserted in the middle of a DIV
        drive(1, 0, 0, 3'b111, 6'b011010); tick();
        drive(0, 0, 0, 3'b000, 6'b000000);
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < DIV_LAT + 4; i++) tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] aop;
            logic [5:0] fn;
            aop = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
            fn  = ($urandom_range(0, 9) < 8) ? pick_funct[$urandom_range(0, 11)] : 6'($urandom);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 19) < 3,
                  $urandom_range(0, 99) < 4, aop, fn);
            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
